ddr2_refresh_scheduler: RTL and testbench

DDR2_REFRESH_SCHEDULER -- requirements
Module: ddr2_refresh_scheduler

---
 rtl/ddr2_refresh_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ddr2_refresh_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_refresh_scheduler.sv
// ----------------------------------------------------------------------------
// ddr2_refresh_scheduler
//
// Purpose:
//    Tracks how many DDR2 AUTO REFRESH commands are owed and asks the command
//    arbiter to issue them. Refreshes are requested opportunistically when the
//    controller is idle, or forcibly once enough of them have piled up. After
//    each issued refresh the block reports the tRFC busy window.
//
// Ports:
//    clk           sole clock, all logic on the rising edge
//    reset         synchronous, active-high
//    enable        initialization complete; the interval counter may run
//    idle_hint     controller has no queued transactions
//    ref_ack       arbiter issued AUTO REFRESH this cycle
//    ref_req       refresh request to the arbiter
//    ref_urgent    the current request may not be deferred any longer
//    ref_busy      inside the tRFC window after a refresh
//    pending_cnt   number of refreshes owed
//    overflow_err  sticky flag, a refresh interval was lost
// ----------------------------------------------------------------------------
module ddr2_refresh_scheduler #(
   parameter int TREFI_CLK     = 100000,
   parameter int TRFC_CLK      = 52,
   parameter int MAX_PENDING   = 8,
   parameter int URGENT_THRESH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       idle_hint,
   input  logic       ref_ack,
   output logic       ref_req,
   output logic       ref_urgent,
   output logic       ref_busy,
   output logic [3:0] pending_cnt,
   output logic       overflow_err
);

   localparam logic [19:0] TREFI_LAST = 20'(TREFI_CLK - 1);
   localparam logic [7:0]  TRFC_LOAD  = 8'(TRFC_CLK - 1);
   localparam logic [3:0]  MAX_P      = 4'(MAX_PENDING);
   localparam logic [3:0]  URGENT_P   = 4'(URGENT_THRESH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RFC  = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [19:0] interval_cnt;
   logic [7:0]  trfc_cnt;
   logic        wrap;
   logic        ack_taken;

   // A wrap marks the end of one refresh interval; it only happens while the
   // counter is allowed to advance. An ack only counts while a request is out,
   // which is what makes stray acks in IDLE or RFC harmless.
   assign wrap      = enable && (interval_cnt == TREFI_LAST);
   assign ack_taken = (state == REQ) && ref_ack;

   // Interval counter: free-running through every FSM state, frozen while
   // the controller has not finished initialization.
   always_ff @(posedge clk) begin
      if (reset) begin
         interval_cnt <= '0;
      end else if (enable) begin
         if (wrap) begin
            interval_cnt <= '0;
         end else begin
            interval_cnt <= interval_cnt + 20'd1;
         end
      end
   end

   // Owed-refresh bookkeeping. A wrap and an accepted ack in the same cycle
   // cancel out. A wrap that finds the ledger already full is a lost refresh
   // and latches the sticky error, which only reset clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_cnt  <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (wrap && !ack_taken) begin
            if (pending_cnt == MAX_P) begin
               overflow_err <= 1'b1;
            end else begin
               pending_cnt <= pending_cnt + 4'd1;
            end
         end else if (ack_taken && !wrap && (pending_cnt != 4'd0)) begin
            pending_cnt <= pending_cnt - 4'd1;
         end
      end
   end

   // tRFC down-counter: loaded on the accepted ack so that counting TRFC_CLK-1
   // down to 0 spans exactly TRFC_CLK cycles of RFC.
   always_ff @(posedge clk) begin
      if (reset) begin
         trfc_cnt <= '0;
      end else if (ack_taken) begin
         trfc_cnt <= TRFC_LOAD;
      end else if ((state == RFC) && (trfc_cnt != 8'd0)) begin
         trfc_cnt <= trfc_cnt - 8'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Once a request is raised it stays up until the arbiter
   // acks it, no matter what enable, idle_hint or the ledger do meanwhile.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (enable && (pending_cnt != 4'd0) &&
                (idle_hint || (pending_cnt >= URGENT_P))) begin
               next_state = REQ;
            end
         end
         REQ: begin
            if (ref_ack) begin
               next_state = RFC;
            end
         end
         RFC: begin
            if (trfc_cnt == 8'd0) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded purely from state and the ledger, so a reset edge
   // clears them on the very next cycle.
   always_comb begin
      ref_req    = 1'b0;
      ref_urgent = 1'b0;
      ref_busy   = 1'b0;
      case (state)
         REQ: begin
            ref_req    = 1'b1;
            ref_urgent = (pending_cnt >= URGENT_P);
         end
         RFC: begin
            ref_busy = 1'b1;
         end
         default: begin
            ref_req = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ddr2_refresh_scheduler
//
// Purpose:
//    Self-checking bench for ddr2_refresh_scheduler with a short refresh
//    interval. Directed segments carry hand-derived expected outputs; a
//    randomized phase is compared every cycle against a behavioural model
//    that tracks owed refreshes, an outstanding request and a busy countdown.
// ----------------------------------------------------------------------------
module tb_ddr2_refresh_scheduler;

   localparam int TREFI = 100;
   localparam int TRFC  = 10;
   localparam int MAXP  = 8;
   localparam int URG   = 4;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       idle_hint;
   logic       ref_ack;
   logic       ref_req;
   logic       ref_urgent;
   logic       ref_busy;
   logic [3:0] pending_cnt;
   logic       overflow_err;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state
   int mTick       = 0;
   int mOwed       = 0;
   bit mRequesting = 0;
   int mBusyLeft   = 0;
   bit mOverflow   = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic       hint;
      logic       ack;
      int         cycles;
      logic       expReq;
      logic       expUrg;
      logic       expBusy;
      logic [3:0] expPend;
      logic       expOvf;
   } vec_t;

   vec_t vecs[$];

   ddr2_refresh_scheduler #(
      .TREFI_CLK(TREFI),
      .TRFC_CLK(TRFC),
      .MAX_PENDING(MAXP),
      .URGENT_THRESH(URG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .idle_hint(idle_hint),
      .ref_ack(ref_ack),
      .ref_req(ref_req),
      .ref_urgent(ref_urgent),
      .ref_busy(ref_busy),
      .pending_cnt(pending_cnt),
      .overflow_err(overflow_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still terminates with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock edge of the model: the interval ends every TREFI enabled
   // cycles, each end adds one owed refresh (or is lost when full), an ack
   // to an outstanding request pays one off and starts TRFC busy cycles.
   task automatic modelStep();
      bit wrap;
      bit accepted;
      int nextOwed;
      if (reset) begin
         mTick = 0; mOwed = 0; mRequesting = 0; mBusyLeft = 0; mOverflow = 0;
         return;
      end
      wrap     = enable && (mTick == TREFI - 1);
      accepted = mRequesting && ref_ack;
      nextOwed = mOwed;
      if (wrap && !accepted) begin
         if (mOwed == MAXP) mOverflow = 1;
         else nextOwed = mOwed + 1;
      end else if (accepted && !wrap) begin
         nextOwed = mOwed - 1;
      end
      if (enable) mTick = wrap ? 0 : mTick + 1;
      if (mRequesting) begin
         if (ref_ack) begin
            mRequesting = 0;
            mBusyLeft   = TRFC;
         end
      end else if (mBusyLeft > 0) begin
         mBusyLeft = mBusyLeft - 1;
      end else if (enable && mOwed > 0 && (idle_hint || mOwed >= URG)) begin
         mRequesting = 1;
      end
      mOwed = nextOwed;
   endtask

   // Hold the given inputs for n rising edges, keeping the model in step,
   // then leave the bench 1 time unit past the last edge for sampling.
   task automatic applyStimulus(input logic rst, input logic en, input logic hint,
                                input logic ack, input int n);
      reset     = rst;
      enable    = en;
      idle_hint = hint;
      ref_ack   = ack;
      repeat (n) begin
         @(posedge clk);
         modelStep();
      end
      #1;
   endtask

   task automatic checkOutput(input string name, input logic eReq, input logic eUrg,
                              input logic eBusy, input logic [3:0] ePend, input logic eOvf);
      compared++;
      if (ref_req !== eReq || ref_urgent !== eUrg || ref_busy !== eBusy ||
          pending_cnt !== ePend || overflow_err !== eOvf) begin
         mismatched++;
         $display("[TB] FAIL %s: actual req=%b urg=%b busy=%b pend=%0d ovf=%b required req=%b urg=%b busy=%b pend=%0d ovf=%b",
                  name, ref_req, ref_urgent, ref_busy, pending_cnt, overflow_err,
                  eReq, eUrg, eBusy, ePend, eOvf);
      end
   endtask

   initial begin
      int ackDiv;
      reset = 1'b1; enable = 1'b0; idle_hint = 1'b0; ref_ack = 1'b0;

      // name, rst, en, hint, ack, cycles, req, urg, busy, pend, ovf
      // Idle-hint refresh with ack two cycles after the request.
      vecs.push_back(vec_t'{"reset_state",    1,0,0,0,   2, 0,0,0,4'd0,0});
      vecs.push_back(vec_t'{"first_wrap",     0,1,1,0, 100, 0,0,0,4'd1,0});
      vecs.push_back(vec_t'{"req_after_wrap", 0,1,1,0,   1, 1,0,0,4'd1,0});
      vecs.push_back(vec_t'{"req_holds",      0,1,1,0,   2, 1,0,0,4'd1,0});
      vecs.push_back(vec_t'{"ack_taken",      0,1,1,1,   1, 0,0,1,4'd0,0});
      vecs.push_back(vec_t'{"busy_last",      0,1,1,0,   9, 0,0,1,4'd0,0});
      vecs.push_back(vec_t'{"busy_done",      0,1,1,0,   1, 0,0,0,4'd0,0});
      // Urgent build-up, saturation and sticky overflow.
      vecs.push_back(vec_t'{"reset2",         1,0,0,0,   1, 0,0,0,4'd0,0});
      vecs.push_back(vec_t'{"pend4_noreq",    0,1,0,0, 400, 0,0,0,4'd4,0});
      vecs.push_back(vec_t'{"urgent_req",     0,1,0,0,   1, 1,1,0,4'd4,0});
      vecs.push_back(vec_t'{"req_held_dis",   0,0,0,0,  50, 1,1,0,4'd4,0});
      vecs.push_back(vec_t'{"pend7",          0,1,0,0, 398, 1,1,0,4'd7,0});
      vecs.push_back(vec_t'{"pend8",          0,1,0,0, 100, 1,1,0,4'd8,0});
      vecs.push_back(vec_t'{"ninth_wrap_ovf", 0,1,0,0,   1, 1,1,0,4'd8,1});
      vecs.push_back(vec_t'{"ack_ovf_sticky", 0,1,0,1,   1, 0,0,1,4'd7,1});
      vecs.push_back(vec_t'{"rereq_sticky",   0,1,0,0,  20, 1,1,0,4'd7,1});
      vecs.push_back(vec_t'{"reset_clears",   1,1,0,1,   1, 0,0,0,4'd0,0});
      // Ack in IDLE with nothing owed, and interval held while disabled.
      vecs.push_back(vec_t'{"idle_ack_dis",   0,0,1,1,  50, 0,0,0,4'd0,0});
      vecs.push_back(vec_t'{"held_then_99",   0,1,0,0,  99, 0,0,0,4'd0,0});
      vecs.push_back(vec_t'{"held_then_100",  0,1,0,0,   1, 0,0,0,4'd1,0});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].hint, vecs[i].ack, vecs[i].cycles);
         checkOutput(vecs[i].name, vecs[i].expReq, vecs[i].expUrg, vecs[i].expBusy,
                     vecs[i].expPend, vecs[i].expOvf);
      end

      // Ack coincident with a wrap at five owed, then acks held through RFC
      // and into IDLE, which must be ignored.
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 599);
      checkOutput("pend5_req", 1, 1, 0, 4'd5, 0);
      applyStimulus(0, 1, 0, 1, 1);
      checkOutput("ack_on_wrap", 0, 0, 1, 4'd5, 0);
      applyStimulus(0, 1, 0, 1, 9);
      checkOutput("rfc_ack_ignored", 0, 0, 1, 4'd5, 0);
      applyStimulus(0, 1, 0, 1, 1);
      checkOutput("rfc_exact_len", 0, 0, 0, 4'd5, 0);
      applyStimulus(0, 1, 0, 1, 1);
      checkOutput("idle_ack_ignored", 1, 1, 0, 4'd5, 0);

      // Reset for one cycle in the middle of a non-urgent request.
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 300);
      checkOutput("pend3_wait", 0, 0, 0, 4'd3, 0);
      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("pend3_req", 1, 0, 0, 4'd3, 0);
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("reset_mid_req", 0, 0, 0, 4'd0, 0);
      applyStimulus(0, 1, 1, 0, 99);
      checkOutput("resume_99", 0, 0, 0, 4'd0, 0);
      applyStimulus(0, 1, 1, 0, 1);
      checkOutput("resume_100", 0, 0, 0, 4'd1, 0);

      // Randomized phase against the model; the second half acks rarely so
      // the ledger climbs towards saturation.
      applyStimulus(1, 0, 0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         ackDiv    = (i < 2000) ? 3 : 60;
         reset     = ($urandom_range(0, 799) == 0);
         enable    = ($urandom_range(0, 9) != 0);
         idle_hint = ($urandom_range(0, 2) == 0);
         ref_ack   = ($urandom_range(0, ackDiv) == 0);
         @(posedge clk);
         modelStep();
         #1;
         checkOutput("random", mRequesting, mRequesting && (mOwed >= URG),
                     (mBusyLeft > 0), 4'(mOwed), mOverflow);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
